// File: rtl/corefifo_sync_ptr_ctrl.sv
// Pointer and flag controller for a single-clock FIFO wrapped around an external RAM.
// Keeps binary and Gray pointers, the occupancy count, status flags and error pulses.
module corefifo_sync_ptr_ctrl #(
    parameter int unsigned ADDRWIDTH  = 3,
    parameter int unsigned AFULL_VAL  = 6,
    parameter int unsigned AEMPTY_VAL = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 WE,
    input  logic                 RE,
    output logic                 MEM_WE,
    output logic                 MEM_RE,
    output logic [ADDRWIDTH-1:0] WADDR,
    output logic [ADDRWIDTH-1:0] RADDR,
    output logic [ADDRWIDTH:0]   WPTR_GRAY,
    output logic [ADDRWIDTH:0]   RPTR_GRAY,
    output logic [ADDRWIDTH:0]   WRCNT,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic                 AFULL,
    output logic                 AEMPTY,
    output logic                 OVERFLOW,
    output logic                 UNDERFLOW,
    output logic                 DVLD
);

    localparam int unsigned    PW    = ADDRWIDTH + 1;
    localparam logic [PW-1:0]  DEPTH = PW'(1) << ADDRWIDTH;

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr_gray;
    logic [PW-1:0] r_rptr_gray;
    logic [PW-1:0] r_cnt;
    logic          r_full;
    logic          r_empty;
    logic          r_afull;
    logic          r_aempty;
    logic          r_overflow;
    logic          r_underflow;
    logic          r_dvld;

    logic          w_mem_we;
    logic          w_mem_re;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;
    logic [PW-1:0] w_cnt_nxt;

    // Accepts are gated by the registered flags only, never by a look-ahead.
    assign w_mem_we   = WE & ~r_full;
    assign w_mem_re   = RE & ~r_empty;
    assign w_wptr_nxt = r_wptr + PW'(w_mem_we);
    assign w_rptr_nxt = r_rptr + PW'(w_mem_re);
    assign w_cnt_nxt  = w_wptr_nxt - w_rptr_nxt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_wptr_gray <= '0;
            r_rptr_gray <= '0;
            r_cnt       <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_dvld      <= 1'b0;
        end else begin
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            r_wptr_gray <= w_wptr_nxt ^ (w_wptr_nxt >> 1);
            r_rptr_gray <= w_rptr_nxt ^ (w_rptr_nxt >> 1);
            r_cnt       <= w_cnt_nxt;
            r_full      <= (w_cnt_nxt == DEPTH);
            r_empty     <= (w_cnt_nxt == '0);
            r_afull     <= (32'(w_cnt_nxt) >= AFULL_VAL);
            r_aempty    <= (32'(w_cnt_nxt) <= AEMPTY_VAL);
            r_overflow  <= WE & r_full;
            r_underflow <= RE & r_empty;
            r_dvld      <= w_mem_re;
        end
    end

    assign MEM_WE    = w_mem_we;
    assign MEM_RE    = w_mem_re;
    assign WADDR     = r_wptr[ADDRWIDTH-1:0];
    assign RADDR     = r_rptr[ADDRWIDTH-1:0];
    assign WPTR_GRAY = r_wptr_gray;
    assign RPTR_GRAY = r_rptr_gray;
    assign WRCNT     = r_cnt;
    assign FULL      = r_full;
    assign EMPTY     = r_empty;
    assign AFULL     = r_afull;
    assign AEMPTY    = r_aempty;
    assign OVERFLOW  = r_overflow;
    assign UNDERFLOW = r_underflow;
    assign DVLD      = r_dvld;

endmodule
